// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch scanner and its record FIFO.
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ERR_W      = 3;
    localparam int unsigned WORD_BYTES = 4;

    // Scanner state encoding, kept as plain constants so legacy code can compare against them.
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t SCAN  = 2'd1;
    localparam state_t STALL = 2'd2;
    localparam state_t DONE  = 2'd3;

    typedef struct packed {
        logic [XLEN-1:0]  addr;
        logic [ERR_W-1:0] code;
    } rec_t;

endpackage

// File: rtl/scan_fifo.sv
// Show-ahead synchronous FIFO of {addr, code} fault records with wrap-bit pointers.
module scan_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  rec_t wdata,
    input  logic pop,
    output logic valid,
    output logic full,
    output rec_t head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    rec_t        mem [DEPTH];
    logic        empty;
    logic        do_push;
    logic        do_pop;

    always_comb begin
        empty   = (wptr == rptr);
        full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        do_pop  = pop && !empty;
        // A pop in the same cycle frees the slot being written when full.
        do_push = push && (!full || do_pop);
        valid   = !empty;
        head    = empty ? '0 : mem[rptr[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fetch_scanner.sv
// Back-pressured instruction-memory scan engine queueing faulting words for a valid/ready consumer.
// Optional saturating error counter enabled with `define SCAN_ERR_COUNT_EN.
module fetch_scanner
    import fetch_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] LIMIT_ADDR = 32'h0000_00FC,
    parameter int unsigned DEPTH      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [XLEN-1:0]  iaddr,
    input  logic [ERR_W-1:0] err_in,
    output logic             rec_valid,
    output logic [XLEN-1:0]  rec_addr,
    output logic [ERR_W-1:0] rec_code,
    input  logic             rec_ready,
    output logic             busy,
    output logic             done,
`ifdef SCAN_ERR_COUNT_EN
    output logic             overflow,
    output logic [15:0]      err_count
`else
    output logic             overflow
`endif
);

    state_t          state;
    state_t          state_n;
    logic [XLEN-1:0] iaddr_n;
    logic            scanning;
    logic            has_err;
    logic            fifo_full;
    logic            can_push;
    logic            push;
    logic            accept;
    logic            launch;
    rec_t            wrec;
    rec_t            head;

    always_comb begin
        scanning = (state == SCAN) || (state == STALL);
        has_err  = (err_in != '0);
        can_push = !fifo_full || (rec_valid && rec_ready);
        push     = scanning && has_err && can_push;
        accept   = scanning && (!has_err || can_push);
        launch   = start && ((state == IDLE) || (state == DONE));
        wrec     = '{addr: iaddr, code: err_in};
    end

    always_comb begin
        state_n = state;
        iaddr_n = iaddr;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = SCAN;
                    iaddr_n = BASE_ADDR;
                end
            end
            SCAN, STALL: begin
                if (accept) begin
                    if (iaddr == LIMIT_ADDR) begin
                        state_n = DONE;
                    end else begin
                        state_n = SCAN;
                        iaddr_n = iaddr + XLEN'(WORD_BYTES);
                    end
                end else begin
                    state_n = STALL;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            iaddr <= BASE_ADDR;
        end else begin
            state <= state_n;
            iaddr <= iaddr_n;
        end
    end

    scan_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .wdata (wrec),
        .pop   (rec_ready),
        .valid (rec_valid),
        .full  (fifo_full),
        .head  (head)
    );

    always_comb begin
        rec_addr = head.addr;
        rec_code = head.code;
        busy     = scanning;
        done     = (state == DONE);
        overflow = 1'b0;
    end

`ifdef SCAN_ERR_COUNT_EN
    // Counted on acceptance only, so a stalled word contributes once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (launch) begin
            err_count <= '0;
        end else if (accept && has_err && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`else
    logic unused_launch;
    assign unused_launch = launch;
`endif

endmodule

// File: tb/tb_fetch_scanner.sv
// Scoreboard bench for fetch_scanner: BASE=0, LIMIT=0x1C, DEPTH=4.
module tb_fetch_scanner;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] iaddr;
    logic [2:0]  err_in;
    logic        rec_valid;
    logic [31:0] rec_addr;
    logic [2:0]  rec_code;
    logic        rec_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef SCAN_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    logic [2:0]  err_tab [8];
    rec_t        sb [$];
    rec_t        exp_rec;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always_comb err_in = err_tab[iaddr[4:2]];

    fetch_scanner #(
        .BASE_ADDR  (32'h0000_0000),
        .LIMIT_ADDR (32'h0000_001C),
        .DEPTH      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .iaddr     (iaddr),
        .err_in    (err_in),
        .rec_valid (rec_valid),
        .rec_addr  (rec_addr),
        .rec_code  (rec_code),
        .rec_ready (rec_ready),
        .busy      (busy),
        .done      (done),
`ifdef SCAN_ERR_COUNT_EN
        .overflow  (overflow),
        .err_count (err_count)
`else
        .overflow  (overflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Load per-word error codes (index = word number) and queue the records they must yield.
    task automatic arm(input logic [7:0][2:0] v);
        for (int i = 0; i < 8; i++) begin
            err_tab[i] = v[i];
            if (v[i] != 3'd0) sb.push_back('{addr: 32'(i * 4), code: v[i]});
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) step();
        check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain(input int budget);
        rec_ready = 1'b1;
        for (int i = 0; i < budget && (sb.size() != 0 || rec_valid || !done); i++) step();
        check("drain_sb", 32'(sb.size()), 32'd0);
        check("drain_valid", 32'(rec_valid), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && rec_valid && rec_ready) begin
            if (sb.size() == 0) begin
                check("sb_extra", 32'(sb.size()), 32'd1);
            end else begin
                exp_rec = sb.pop_front();
                check("rec_addr", rec_addr, exp_rec.addr);
                check("rec_code", 32'(rec_code), 32'(exp_rec.code));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) err_tab[i] = 3'd0;
        #1;
        check("rst_iaddr", iaddr, 32'h0);
        check("rst_valid", 32'(rec_valid), 32'd0);
        check("rst_raddr", rec_addr, 32'h0);
        check("rst_rcode", 32'(rec_code), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        step();

        // Clean scan
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("clean_iaddr", iaddr, 32'(i * 4));
            check("clean_busy", 32'(busy), 32'd1);
            check("clean_done", 32'(done), 32'd0);
            check("clean_valid", 32'(rec_valid), 32'd0);
            step();
        end
        @(negedge clk);
        check("clean_done_rise", 32'(done), 32'd1);
        check("clean_busy_low", 32'(busy), 32'd0);
        check("clean_hold", iaddr, 32'h1C);
        step();

        // Two errors, consumer always ready: no stall
        rec_ready = 1'b1;
        arm({3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0});
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("err2_iaddr", iaddr, 32'(i * 4));
            step();
        end
        @(negedge clk);
        check("err2_done", 32'(done), 32'd1);
        step();
        drain(20);

        // Every word faults, consumer blocked: stall at 0x10
        rec_ready = 1'b0;
        arm({3'd1, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1});
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fill_iaddr", iaddr, 32'(i * 4));
            step();
        end
        @(negedge clk);
        check("stall_iaddr", iaddr, 32'h10);
        step();
        @(negedge clk);
        check("stall_hold1", iaddr, 32'h10);
        check("stall_busy", 32'(busy), 32'd1);
        step();
        @(negedge clk);
        check("stall_hold2", iaddr, 32'h10);
        step();
        rec_ready = 1'b1;
        @(negedge clk);
        check("pop_cycle_iaddr", iaddr, 32'h10);
        step();
        rec_ready = 1'b0;
        @(negedge clk);
        check("advance_iaddr", iaddr, 32'h14);
        step();
        @(negedge clk);
        check("restall_iaddr", iaddr, 32'h14);
        check("restall_done", 32'(done), 32'd0);
        step();
        drain(60);
        check("stall_done", 32'(done), 32'd1);
`ifdef SCAN_ERR_COUNT_EN
        check("cnt_total", 32'(err_count), 32'd8);
`endif

        // Async reset mid-scan with three records queued
        rec_ready = 1'b0;
        arm({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2, 3'd1});
        pulse_start();
`ifdef SCAN_ERR_COUNT_EN
        @(negedge clk);
        check("cnt_cleared", 32'(err_count), 32'd0);
`endif
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        check("pre_rst_iaddr", iaddr, 32'h10);
        check("pre_rst_valid", 32'(rec_valid), 32'd1);
        check("pre_rst_raddr", rec_addr, 32'h0);
        check("pre_rst_rcode", 32'(rec_code), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_iaddr", iaddr, 32'h0);
        check("mid_rst_valid", 32'(rec_valid), 32'd0);
        check("mid_rst_raddr", rec_addr, 32'h0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_valid", 32'(rec_valid), 32'd0);
        step();

        // Restart from BASE; start mid-scan is ignored
        arm({3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0});
        pulse_start();
        @(negedge clk);
        check("restart_iaddr0", iaddr, 32'h0);
        step();
        @(negedge clk);
        check("restart_iaddr1", iaddr, 32'h4);
        step();
        pulse_start();
        @(negedge clk);
        check("ign_start_iaddr", iaddr, 32'hC);
        check("ign_start_busy", 32'(busy), 32'd1);
        step();
        wait_done(20);

        // Undrained records survive a restart; new ones queue behind them
        arm({3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd0});
        pulse_start();
        wait_done(20);
`ifdef SCAN_ERR_COUNT_EN
        check("cnt_two", 32'(err_count), 32'd2);
`endif
        @(negedge clk);
        check("keep_valid", 32'(rec_valid), 32'd1);
        check("keep_head", rec_addr, 32'h4);
        step();
        arm({3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd2});
        pulse_start();
        wait_done(20);
        @(negedge clk);
        check("rescan_head", rec_addr, 32'h4);
        check("rescan_code", 32'(rec_code), 32'd6);
        step();
        drain(30);
        check("ovf_clear", 32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
